// File: rtl/elgamal_modinv.sv
// Sequential modular inverse: inv = x^-1 mod q via iterative extended Euclid,
// with one restoring shift-subtract division (one quotient bit per cycle) per step.
module elgamal_modinv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] inv
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        FINAL
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        q_reg;
    logic [WIDTH-1:0]        old_r;
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH+1:0] old_t;
    logic signed [WIDTH+1:0] t;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        rem;
    logic [CW-1:0]           cnt;

    logic [WIDTH:0]            rem_shift;
    logic [WIDTH:0]            rem_sub;
    logic                      fits;
    logic signed [2*WIDTH+1:0] prod;
    logic signed [WIDTH+1:0]   t_next;
    logic signed [WIDTH+1:0]   t_fix;
    logic                      err_n;
    logic [WIDTH-1:0]          inv_n;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        rem_shift = '0;
        rem_sub   = '0;
        fits      = 1'b0;
        prod      = '0;
        t_next    = '0;
        t_fix     = '0;
        err_n     = 1'b0;
        inv_n     = '0;

        // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
        rem_shift = {rem, quo[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, r};
        fits      = (rem_shift >= {1'b0, r});

        prod   = $signed({{(WIDTH+2){1'b0}}, quo}) * $signed({{WIDTH{t[WIDTH+1]}}, t});
        t_next = old_t - prod[WIDTH+1:0];

        t_fix = (old_t < 0) ? (old_t + $signed({2'b00, q_reg})) : old_t;
        err_n = (q_reg < WIDTH'(2)) || (old_r != WIDTH'(1));
        inv_n = err_n ? '0 : t_fix[WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so the
    // simultaneous (old_r,r) and (old_t,t) updates read pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            inv   <= '0;
            q_reg <= '0;
            old_r <= '0;
            r     <= '0;
            old_t <= '0;
            t     <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= q;
                        old_r <= q;
                        r     <= x;
                        old_t <= '0;
                        t     <= 'sd1;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        inv   <= '0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (q_reg < WIDTH'(2) || r == '0) begin
                        state <= FINAL;
                    end else begin
                        quo   <= old_r;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= fits ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= UPDATE;
                end
                UPDATE: begin
                    old_r <= r;
                    r     <= rem;
                    old_t <= t;
                    t     <= t_next;
                    if (rem == '0) begin
                        state <= FINAL;
                    end else begin
                        // The next dividend is the divisor just retired into old_r.
                        quo   <= r;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                FINAL: begin
                    err   <= err_n;
                    inv   <= inv_n;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elgamal_modinv.sv
// Directed bench for elgamal_modinv: latency, results, handshake and reset.
module tb_elgamal_modinv;

    localparam int WIDTH  = 32;
    localparam int BUDGET = 2000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] inv;

    int total;
    int bad;

    elgamal_modinv #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .x    (x),
        .q    (q),
        .busy (busy),
        .done (done),
        .err  (err),
        .inv  (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start, scramble the operands after acceptance, and wait for done.
    task automatic run_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] qv,
                          output int lat, output logic busy_after,
                          output logic [WIDTH-1:0] inv_o, output logic err_o,
                          output logic timed_out);
        @(negedge clk);
        x     = xv;
        q     = qv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        x          = 32'hDEAD_BEEF;
        q          = 32'h0000_0005;
        busy_after = busy;
        lat        = 0;
        timed_out  = 1'b1;
        inv_o      = '0;
        err_o      = 1'b0;
        while (lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                timed_out = 1'b0;
                inv_o     = inv;
                err_o     = err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        q     = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, inv} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b inv=%0d, expected all 0",
                     busy, done, err, inv);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vector(input string name, input logic [WIDTH-1:0] xv,
                               input logic [WIDTH-1:0] qv, input int exp_lat,
                               input logic [WIDTH-1:0] exp_inv, input logic exp_err);
        int lat;
        logic b, e, to;
        logic [WIDTH-1:0] iv;
        run_op(xv, qv, lat, b, iv, e, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, BUDGET);
            return;
        end
        if (lat != exp_lat || iv !== exp_inv || e !== exp_err || b !== 1'b1) begin
            bad++;
            $display("FAIL %s: lat=%0d inv=%0d err=%b busy=%b, expected lat=%0d inv=%0d err=%b busy=1",
                     name, lat, iv, e, b, exp_lat, exp_inv, exp_err);
        end
    endtask

    task automatic test_done_pulse_hold;
        int lat;
        logic b, e, to;
        logic [WIDTH-1:0] iv;
        run_op(32'd2, 32'd7, lat, b, iv, e, to);
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_width: done=%b busy=%b one cycle after done, expected 0 0", done, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (inv !== 32'd4 || err !== 1'b0) begin
            bad++;
            $display("FAIL inv_hold: inv=%0d err=%b, expected 4 0", inv, err);
        end
    endtask

    task automatic test_start_while_busy;
        int dones;
        logic [WIDTH-1:0] last_inv;
        logic last_err;
        dones    = 0;
        last_inv = '0;
        last_err = 1'b0;
        @(negedge clk);
        x     = 32'd2;
        q     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        x     = 32'd6;
        q     = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                last_inv = inv;
                last_err = err;
            end
        end
        total++;
        if (dones != 1 || last_inv !== 32'd4 || last_err !== 1'b0) begin
            bad++;
            $display("FAIL start_while_busy: dones=%0d inv=%0d err=%b, expected 1 4 0",
                     dones, last_inv, last_err);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic b, e, to;
        logic [WIDTH-1:0] iv;
        logic got;
        run_op(32'd3, 32'd7, lat, b, iv, e, to);
        total++;
        if (to || iv !== 32'd5) begin
            bad++;
            $display("FAIL b2b_first: inv=%0d timeout=%b, expected 5 0", iv, to);
        end
        // Still inside the done cycle: this start must be taken at the next edge.
        x     = 32'd10;
        q     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || inv !== 32'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b inv=%0d err=%b, expected 1 0 0", busy, inv, err);
        end
        lat = 0;
        got = 1'b0;
        while (lat < BUDGET && !got) begin
            @(posedge clk);
            #1;
            lat++;
            got = done;
        end
        total++;
        if (!got || lat != 134 || inv !== 32'd5 || err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: done=%b lat=%0d inv=%0d err=%b, expected 1 134 5 0",
                     got, lat, inv, err);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones;
        @(negedge clk);
        x     = 32'd2;
        q     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // One CHECK edge plus ten DIV edges, then reset at the following edge.
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, inv} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL mid_reset_state: busy=%b done=%b err=%b inv=%0d, expected all 0",
                     busy, done, err, inv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL mid_reset_no_done: dones=%0d, expected 0", dones);
        end
        test_vector("after_reset", 32'd3, 32'd7, 68, 32'd5, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vector("nominal",   32'd2,  32'd7, 68,  32'd4, 1'b0);
        test_vector("neg_fixup", 32'd3,  32'd7, 68,  32'd5, 1'b0);
        test_vector("x_above_q", 32'd10, 32'd7, 134, 32'd5, 1'b0);
        test_vector("no_inv",    32'd6,  32'd9, 68,  32'd0, 1'b1);
        test_vector("x_zero",    32'd0,  32'd7, 2,   32'd0, 1'b1);
        test_vector("q_one",     32'd5,  32'd1, 2,   32'd0, 1'b1);
        test_vector("q_zero",    32'd5,  32'd0, 2,   32'd0, 1'b1);
        test_vector("x_one",     32'd1,  32'd7, 35,  32'd1, 1'b0);
        test_done_pulse_hold();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elgamal_modinv.md
Name: elgamal_modinv

Overview:
- Sequential modular-inverse unit. Computes inv = x^-1 mod q with the iterative extended Euclidean algorithm.
- Sits between the shared-secret exponentiator (g^(a·k) mod q) and the decryption stage, and replaces the constant inverse the decryptor uses today.
- The exponentiator result drives x. The decryptor consumes inv when done pulses.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk    input   1      clock, rising edge
- rst_n  input   1      synchronous active-low reset
- start  input   1      request; sampled only in IDLE
- x      input   WIDTH  value to invert (unsigned, may be >= q)
- q      input   WIDTH  modulus (unsigned)
- busy   output  1      high from the cycle after start is accepted until done
- done   output  1      one-cycle pulse; inv and err are valid this cycle
- err    output  1      no inverse exists (gcd(x,q)!=1, x mod q==0, or q<2)
- inv    output  WIDTH  inverse in [1,q-1]; 0 when err

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, err=0, inv=0; internal registers cleared. This holds mid-operation; the in-flight computation is discarded and no done is produced.
- IDLE: start=1 latches x and q, sets busy=1 and goes to CHECK. start in any other state is ignored (no queueing).
- Internal registers:
  - old_r, r: WIDTH unsigned, init q and x.
  - old_t, t: signed WIDTH+2, init 0 and 1.
  - quo: WIDTH unsigned.
- CHECK (1 cycle): if q<2 or r==0, go to FINAL. Otherwise go to DIV.
- DIV (exactly WIDTH cycles): restoring shift-subtract division, one quotient bit per cycle, MSB first. Produces quo=old_r/r and rem=old_r%r. r!=0 is guaranteed on entry.
- UPDATE (1 cycle), simultaneous assignment: (old_r,r) <= (r, rem); (old_t,t) <= (t, old_t − quo·t).
  - The product is computed at 2·WIDTH+2 bits and truncated to WIDTH+2 signed. |t| <= q is guaranteed, so no overflow.
  - If the new r==0, go to FINAL; else go to DIV.
  - x>=q needs no special handling: the first quotient is 0 and the step acts as a swap.
- FINAL (1 cycle):
  - err_n = (q<2) or (old_r!=1).
  - inv_n = err_n ? 0 : (old_t<0 ? old_t+q : old_t), truncated to WIDTH.
  - Next edge: state=IDLE, done=1, busy=0, err=err_n, inv=inv_n.
- done is high for exactly one cycle. inv and err hold their values until the next accepted start, which clears err and inv the edge it is sampled.
- Latency: let N be the number of Euclid iterations (UPDATE visits). The edge that samples start and the edge that raises done are L = N·(WIDTH+1)+2 edges apart. When N=0 (x==0 or q<2), L=2.
- start=1 in the same cycle done=1 is accepted, because the state is already IDLE.
- Inputs x and q may change after start is accepted without effect, since they are latched.

Test Plan:
- Nominal: WIDTH=32, x=2, q=7, start for 1 cycle -> N=2, done 68 edges after start, inv=4, err=0. Output matches 2·4 mod 7 = 1, the existing decrypt constant.
- Negative coefficient fix-up: x=3, q=7 -> old_t=-2 corrected to inv=5, err=0, L=68.
- Operand above modulus: x=10, q=7 -> N=4, inv=5, err=0, L=134.
- No inverse: x=6, q=9 -> gcd 3, err=1, inv=0, L=68. Degenerate cases: x=0, q=7 -> err=1, L=2; q=1 -> err=1, L=2.
- Handshake:
  - start pulsed while busy is ignored: a single done, result from the first operands.
  - start asserted in the done cycle begins a new run; busy rises the next cycle.
  - done stays high for exactly 1 cycle; inv holds after done.
- Reset mid-run: rst_n=0 at DIV cycle 10 of x=2, q=7 -> next cycle busy=0, done=0, inv=0, err=0, and no done pulse follows. A later start with x=3, q=7 returns inv=5.
